ucode_seq: RTL and testbench

UCODE_SEQ -- requirements
Module: ucode_seq

---
 rtl/ucode_seq_pkg.sv | 43 ++++
 rtl/ucode_store.sv | 59 +++++
 rtl/ucode_seq.sv | 136 +++++++++++++
 tb/tb_ucode_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ucode_seq_pkg.sv
// ucode_seq_pkg: shared definitions for the microcode sequencer.
//   - op_t        : microcode op codes (codes 5-7 are illegal)
//   - CFG_SEL_*   : configuration write targets
//   - DEF_*       : default program loaded on reset
//   - def_op / def_target : default microcode word for a given index
package ucode_seq_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_SEQ   = 3'd0,
    OP_DISP1 = 3'd1,
    OP_JUMP  = 3'd2,
    OP_DISP2 = 3'd3,
    OP_RET   = 3'd4
  } op_t;

  localparam logic [1:0] CFG_SEL_UCODE = 2'd0;
  localparam logic [1:0] CFG_SEL_DISP1 = 2'd1;
  localparam logic [1:0] CFG_SEL_DISP2 = 2'd2;
  localparam logic [1:0] CFG_SEL_RSVD  = 2'd3;

  localparam int unsigned DEF_JUMP_TARGET = 7;
  localparam int unsigned DEF_DISP1 [4] = '{4, 5, 6, 6};
  localparam int unsigned DEF_DISP2 [4] = '{11, 12, 12, 12};

  // Default program: 0-2 SEQ, 3 DISP1, 4-5 JUMP 7, 6-9 SEQ, 10 DISP2,
  // everything from 11 upward RET.
  function automatic op_t def_op(input int unsigned idx);
    if (idx <= 2)                 return OP_SEQ;
    else if (idx == 3)            return OP_DISP1;
    else if (idx <= 5)            return OP_JUMP;
    else if (idx <= 9)            return OP_SEQ;
    else if (idx == 10)           return OP_DISP2;
    else                          return OP_RET;
  endfunction

  function automatic int unsigned def_target(input int unsigned idx);
    if (idx == 4 || idx == 5) return DEF_JUMP_TARGET;
    else                      return 0;
  endfunction

endpackage

// File: rtl/ucode_store.sv
// ucode_store: microcode and dispatch-table storage with default load.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (loads defaults)
//   we, sel, addr,
//   data            : write port (sel picks microcode / disp1 / disp2)
//   rd_addr         : microcode read address (combinational read)
//   y               : dispatch index for both tables
//   op, target      : microcode word at rd_addr
//   disp1_next,
//   disp2_next      : dispatch table entries selected by y
module ucode_store
  import ucode_seq_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [1:0]              sel,
  input  logic [STATE_W-1:0]      addr,
  input  logic [OP_W+STATE_W-1:0] data,
  input  logic [STATE_W-1:0]      rd_addr,
  input  logic [1:0]              y,
  output logic [OP_W-1:0]         op,
  output logic [STATE_W-1:0]      target,
  output logic [STATE_W-1:0]      disp1_next,
  output logic [STATE_W-1:0]      disp2_next
);

  localparam int unsigned DEPTH = 2**STATE_W;

  logic [OP_W+STATE_W-1:0] mem   [DEPTH];
  logic [STATE_W-1:0]      disp1 [4];
  logic [STATE_W-1:0]      disp2 [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= {def_op(i), STATE_W'(def_target(i))};
      end
      for (int unsigned i = 0; i < 4; i++) begin
        disp1[i] <= STATE_W'(DEF_DISP1[i]);
        disp2[i] <= STATE_W'(DEF_DISP2[i]);
      end
    end else if (we) begin
      unique case (sel)
        CFG_SEL_UCODE: mem[addr]         <= data;
        CFG_SEL_DISP1: disp1[addr[1:0]]  <= data[STATE_W-1:0];
        CFG_SEL_DISP2: disp2[addr[1:0]]  <= data[STATE_W-1:0];
        CFG_SEL_RSVD:  ;
      endcase
    end
  end

  assign {op, target} = mem[rd_addr];
  assign disp1_next   = disp1[y];
  assign disp2_next   = disp2[y];

endmodule

// File: rtl/ucode_seq.sv
// ucode_seq: microcode sequencer with two dispatch tables.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin a run at state 0 (ignored while busy)
//   y            : branch condition for DISP1/DISP2
//   cfg_we, cfg_sel, cfg_addr, cfg_data : configuration write (IDLE only)
//   state        : current microcode address
//   busy         : run in progress
//   done         : one-cycle pulse after RET
//   err          : sticky illegal-opcode flag, cleared by accepted start
//   cfg_rej      : one-cycle pulse when a write arrives while busy
//   run_cycles   : RUN-cycle counter, only with UCODE_SEQ_CYCLE_CNT_EN
module ucode_seq
  import ucode_seq_pkg::*;
#(
  parameter int unsigned STATE_W = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              y,
  input  logic                    cfg_we,
  input  logic [1:0]              cfg_sel,
  input  logic [STATE_W-1:0]      cfg_addr,
  input  logic [OP_W+STATE_W-1:0] cfg_data,
  output logic [STATE_W-1:0]      state,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    cfg_rej
`ifdef UCODE_SEQ_CYCLE_CNT_EN
  ,
  output logic [CNT_W-1:0]        run_cycles
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } fsm_t;

  fsm_t               fsm, fsm_nxt;
  logic [STATE_W-1:0] state_nxt;
  logic               err_nxt;
  logic               done_nxt;
  logic               store_we;
  logic [OP_W-1:0]    op;
  logic [STATE_W-1:0] target;
  logic [STATE_W-1:0] disp1_next;
  logic [STATE_W-1:0] disp2_next;

  // Writes land only in IDLE; a same-cycle start then reads the new contents.
  assign store_we = cfg_we && (fsm == S_IDLE);
  assign busy     = (fsm == S_RUN);

  ucode_store #(
    .STATE_W (STATE_W)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .we         (store_we),
    .sel        (cfg_sel),
    .addr       (cfg_addr),
    .data       (cfg_data),
    .rd_addr    (state),
    .y          (y),
    .op         (op),
    .target     (target),
    .disp1_next (disp1_next),
    .disp2_next (disp2_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm     <= S_IDLE;
      state   <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
      cfg_rej <= 1'b0;
    end else begin
      fsm     <= fsm_nxt;
      state   <= state_nxt;
      err     <= err_nxt;
      done    <= done_nxt;
      cfg_rej <= cfg_we && (fsm == S_RUN);
    end
  end

  always_comb begin
    fsm_nxt   = fsm;
    state_nxt = state;
    err_nxt   = err;
    done_nxt  = 1'b0;
    unique case (fsm)
      S_IDLE: begin
        if (start) begin
          fsm_nxt   = S_RUN;
          state_nxt = '0;
          err_nxt   = 1'b0;
        end
      end
      S_RUN: begin
        case (op)
          OP_SEQ:   state_nxt = state + 1'b1;
          OP_DISP1: state_nxt = disp1_next;
          OP_JUMP:  state_nxt = target;
          OP_DISP2: state_nxt = disp2_next;
          OP_RET: begin
            state_nxt = '0;
            fsm_nxt   = S_IDLE;
            done_nxt  = 1'b1;
          end
          default: begin
            state_nxt = '0;
            fsm_nxt   = S_IDLE;
            err_nxt   = 1'b1;
          end
        endcase
      end
    endcase
  end

`ifdef UCODE_SEQ_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cycles <= '0;
    end else if (fsm == S_IDLE && start) begin
      run_cycles <= '0;
    end else if (fsm == S_RUN && run_cycles != '1) begin
      run_cycles <= run_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ucode_seq.sv
module tb_ucode_seq;
  import ucode_seq_pkg::*;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [1:0]         y = 2'd0;
  logic               cfg_we = 1'b0;
  logic [1:0]         cfg_sel = 2'd0;
  logic [STATE_W-1:0] cfg_addr = '0;
  logic [6:0]         cfg_data = '0;
  logic [STATE_W-1:0] state;
  logic               busy, done, err, cfg_rej;
`ifdef UCODE_SEQ_CYCLE_CNT_EN
  logic [CNT_W-1:0]   run_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ucode_seq #(
    .STATE_W (STATE_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .y          (y),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .state      (state),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cfg_rej    (cfg_rej)
`ifdef UCODE_SEQ_CYCLE_CNT_EN
    ,
    .run_cycles (run_cycles)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; cfg_we = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [3:0] addr, input logic [6:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
    n_checks++; if (cfg_rej !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_rej got %b exp 0", cfg_rej); end
`ifdef UCODE_SEQ_CYCLE_CNT_EN
    n_checks++; if (run_cycles !== 4'd0) begin n_fail++; $display("FAIL reset_run_cycles got %0d exp 0", run_cycles); end
`endif
  endtask

  task automatic test_dispatch_y01();
    int exp_states [10] = '{0, 1, 2, 3, 5, 7, 8, 9, 10, 12};
    do_reset();
    y = 2'b01;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (state !== 4'(exp_states[i]) || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL y01_step%0d got state=%0d busy=%b done=%b exp state=%0d busy=1 done=0",
                 i, state, busy, done, exp_states[i]);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || state !== 4'd0) begin
      n_fail++;
      $display("FAIL y01_end got done=%b busy=%b state=%0d exp done=1 busy=0 state=0", done, busy, state);
    end
`ifdef UCODE_SEQ_CYCLE_CNT_EN
    n_checks++; if (run_cycles !== 4'd10) begin n_fail++; $display("FAIL y01_run_cycles got %0d exp 10", run_cycles); end
`endif
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL y01_done_pulse got %b exp 0", done); end
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL y01_idle_hold got %0d exp 0", state); end
`ifdef UCODE_SEQ_CYCLE_CNT_EN
    n_checks++; if (run_cycles !== 4'd10) begin n_fail++; $display("FAIL y01_run_cycles_hold got %0d exp 10", run_cycles); end
`endif
  endtask

  // Also pulses start mid-run, which must be ignored.
  task automatic test_dispatch_y00();
    int exp_states [10] = '{0, 1, 2, 3, 4, 7, 8, 9, 10, 11};
    do_reset();
    y = 2'b00;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (state !== 4'(exp_states[i]) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL y00_step%0d got state=%0d busy=%b exp state=%0d busy=1", i, state, busy, exp_states[i]);
      end
      start = (i == 5);
      tick();
    end
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || state !== 4'd0) begin
      n_fail++;
      $display("FAIL y00_end got done=%b busy=%b state=%0d exp done=1 busy=0 state=0", done, busy, state);
    end
`ifdef UCODE_SEQ_CYCLE_CNT_EN
    n_checks++; if (run_cycles !== 4'd10) begin n_fail++; $display("FAIL y00_run_cycles got %0d exp 10", run_cycles); end
`endif
  endtask

  task automatic test_illegal_op();
    do_reset();
    // write op 5 to entry 0 in the same cycle as start
    cfg_we = 1'b1; cfg_sel = CFG_SEL_UCODE; cfg_addr = 4'd0; cfg_data = {3'd5, 4'd0};
    start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || state !== 4'd0 || cfg_rej !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_start got busy=%b state=%0d cfg_rej=%b exp busy=1 state=0 cfg_rej=0", busy, state, cfg_rej);
    end
    tick();
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || state !== 4'd0) begin
      n_fail++;
      $display("FAIL illegal_err got err=%b busy=%b done=%b state=%0d exp err=1 busy=0 done=0 state=0",
               err, busy, done, state);
    end
    tick();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky got %b exp 1", err); end
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL illegal_clear got err=%b busy=%b exp err=0 busy=1", err, busy);
    end
    tick();
    n_checks++; if (err !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL illegal_again got err=%b done=%b exp err=1 done=0", err, done);
    end
  endtask

  task automatic test_cfg_reject();
    do_reset();
    y = 2'b01;
    start = 1'b1; tick(); start = 1'b0;
    cfg_we = 1'b1; cfg_sel = CFG_SEL_DISP1; cfg_addr = 4'd1; cfg_data = 7'd9;
    tick();
    cfg_we = 1'b0;
    n_checks++; if (cfg_rej !== 1'b1) begin n_fail++; $display("FAIL cfg_rej_pulse got %b exp 1", cfg_rej); end
    tick();
    n_checks++; if (cfg_rej !== 1'b0) begin n_fail++; $display("FAIL cfg_rej_clear got %b exp 0", cfg_rej); end
    for (int k = 0; k < 40 && busy; k++) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cfg_rej_run_end got busy=%b exp 0", busy); end
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    n_checks++; if (state !== 4'd5) begin n_fail++; $display("FAIL cfg_rej_disp1 got %0d exp 5", state); end
  endtask

  task automatic test_rst_mid_run();
    do_reset();
    cfg_write(CFG_SEL_DISP1, 4'd1, 7'd9);
    y = 2'b00;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    n_checks++; if (state !== 4'd8) begin n_fail++; $display("FAIL rst_mid_reach got %0d exp 8", state); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++;
    if (state !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_abort got state=%0d busy=%b done=%b exp 0 0 0", state, busy, done);
    end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_done got %b exp 0", done); end
    y = 2'b01;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    n_checks++; if (state !== 4'd5) begin n_fail++; $display("FAIL rst_mid_tables got %0d exp 5", state); end
  endtask

  task automatic test_wrap_saturate();
    do_reset();
    for (int a = 0; a < 16; a++) cfg_write(CFG_SEL_UCODE, 4'(a), 7'd0);
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    n_checks++; if (state !== 4'd15) begin n_fail++; $display("FAIL wrap_top got %0d exp 15", state); end
    tick();
    n_checks++; if (state !== 4'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL wrap_zero got state=%0d busy=%b exp state=0 busy=1", state, busy);
    end
`ifdef UCODE_SEQ_CYCLE_CNT_EN
    n_checks++; if (run_cycles !== 4'd15) begin n_fail++; $display("FAIL sat_reach got %0d exp 15", run_cycles); end
    for (int k = 0; k < 20; k++) tick();
    n_checks++; if (run_cycles !== 4'd15) begin n_fail++; $display("FAIL sat_hold got %0d exp 15", run_cycles); end
`endif
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++; if (busy !== 1'b0 || state !== 4'd0) begin
      n_fail++; $display("FAIL wrap_rst got busy=%b state=%0d exp busy=0 state=0", busy, state);
    end
`ifdef UCODE_SEQ_CYCLE_CNT_EN
    n_checks++; if (run_cycles !== 4'd0) begin n_fail++; $display("FAIL sat_rst got %0d exp 0", run_cycles); end
`endif
  endtask

  initial begin
    test_reset();
    test_dispatch_y01();
    test_dispatch_y00();
    test_illegal_op();
    test_cfg_reject();
    test_rst_mid_run();
    test_wrap_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
